// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the 8-bit pipeline: opcodes, instruction field
// positions, default widths and a small per-opcode operand-usage lookup.
package decode_stage_pkg;

    localparam int DW_DEFAULT   = 8;
    localparam int NREG_DEFAULT = 4;
    localparam int ILEN         = 16;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes (shared with the ALU); 1010-1111 are illegal
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_LOADC = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1001;

    typedef struct packed {
        logic legal;    // opcode is defined
        logic reads_rd; // R[rd] is a source (op1 or store data)
        logic reads_rs; // R[rs] is a source (op2)
        logic writes;   // instruction writes rd
    } op_info_t;

    // Which register fields an opcode reads and whether it writes rd.
    function automatic op_info_t op_info(input logic [3:0] opc);
        op_info_t info;
        info = '0;
        case (opc)
            OP_NOP:   info = '{legal: 1'b1, reads_rd: 1'b0, reads_rs: 1'b0, writes: 1'b0};
            OP_ADD,
            OP_XOR,
            OP_AND:   info = '{legal: 1'b1, reads_rd: 1'b1, reads_rs: 1'b1, writes: 1'b1};
            OP_ADDI,
            OP_SHL,
            OP_SHR:   info = '{legal: 1'b1, reads_rd: 1'b1, reads_rs: 1'b0, writes: 1'b1};
            OP_LOAD,
            OP_LOADC: info = '{legal: 1'b1, reads_rd: 1'b0, reads_rs: 1'b0, writes: 1'b1};
            OP_STORE: info = '{legal: 1'b1, reads_rd: 1'b1, reads_rs: 1'b0, writes: 1'b0};
            default:  info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file: NREG x DW, one synchronous write port, two combinational
// read ports, asynchronous clear. No write-through; the decode stage bypasses.
module reg_file
    import decode_stage_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr_a,
    output logic [DW-1:0] rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_b
);

    logic [DW-1:0] regs [NREG];

    // Storage update: clear on reset, write on enabled clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode / operand fetch. Reads the register file, forwards from
// EX, MEM and WB, stalls IF for one cycle on a load-use dependency and
// registers the ALU-facing ID/EX fields.
//
// Handshake: IF presents if_instr when if_valid is high. The instruction is
// consumed on a rising edge only when if_stall is low; while if_stall is high
// IF must hold if_instr and the stage issues a bubble instead.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [ILEN-1:0] if_instr,
    output logic            if_stall,
    input  logic [DW-1:0]   ex_alu_out,
    input  logic            mem_fwd_en,
    input  logic [AW-1:0]   mem_fwd_rd,
    input  logic [DW-1:0]   mem_fwd_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [DW-1:0]   wb_data,
    output logic            id_valid,
    output logic [3:0]      id_mode,
    output logic [DW-1:0]   id_operand1,
    output logic [DW-1:0]   id_operand2,
    output logic [DW-1:0]   id_store_data,
    output logic [AW-1:0]   id_rd,
    output logic            id_wr_en
);

    logic [3:0]    opc;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rs_idx;
    logic [7:0]    imm8;
    op_info_t      info;

    assign opc    = if_instr[OPC_MSB:OPC_LSB];
    assign rd_idx = if_instr[RD_MSB:RD_LSB];
    assign rs_idx = if_instr[RS_MSB:RS_LSB];
    assign imm8   = if_instr[IMM_MSB:IMM_LSB];
    assign info   = op_info(opc);

    logic [DW-1:0] rf_rd_val;
    logic [DW-1:0] rf_rs_val;

    reg_file #(
        .DW   (DW),
        .NREG (NREG)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_en),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data),
        .rd_addr_a (rd_idx),
        .rd_data_a (rf_rd_val),
        .rd_addr_b (rs_idx),
        .rd_data_b (rf_rs_val)
    );

    // A LOAD in EX has no data yet, so it is never an EX forwarding source.
    logic ex_fwd_ok;
    logic load_in_ex;
    logic hazard;

    assign ex_fwd_ok  = id_valid && id_wr_en && (id_mode != OP_LOAD);
    assign load_in_ex = id_valid && id_wr_en && (id_mode == OP_LOAD);
    assign hazard     = if_valid && load_in_ex &&
                        ((info.reads_rd && (rd_idx == id_rd)) ||
                         (info.reads_rs && (rs_idx == id_rd)));
    assign if_stall   = hazard;

    logic [DW-1:0] rd_val;
    logic [DW-1:0] rs_val;

    // Source selection, lowest priority first so later matches override:
    // register file, WB write-through, MEM forward, EX forward.
    always_comb begin
        rd_val = rf_rd_val;
        if (wb_en && (wb_rd == rd_idx))           rd_val = wb_data;
        if (mem_fwd_en && (mem_fwd_rd == rd_idx)) rd_val = mem_fwd_data;
        if (ex_fwd_ok && (id_rd == rd_idx))       rd_val = ex_alu_out;

        rs_val = rf_rs_val;
        if (wb_en && (wb_rd == rs_idx))           rs_val = wb_data;
        if (mem_fwd_en && (mem_fwd_rd == rs_idx)) rs_val = mem_fwd_data;
        if (ex_fwd_ok && (id_rd == rs_idx))       rs_val = ex_alu_out;
    end

    logic            nxt_valid;
    logic [3:0]      nxt_mode;
    logic [DW-1:0]   nxt_op1;
    logic [DW-1:0]   nxt_op2;
    logic [DW-1:0]   nxt_store;
    logic [AW-1:0]   nxt_rd;
    logic            nxt_wr_en;

    // Next ID/EX contents: bubble when idle or stalled, otherwise map operands
    // by opcode; illegal opcodes issue as a valid NOP.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_mode  = OP_NOP;
        nxt_op1   = '0;
        nxt_op2   = '0;
        nxt_store = '0;
        nxt_rd    = '0;
        nxt_wr_en = 1'b0;
        if (if_valid && !hazard) begin
            nxt_valid = 1'b1;
            if (info.legal) begin
                nxt_mode  = opc;
                nxt_wr_en = info.writes;
                nxt_rd    = info.writes ? rd_idx : '0;
                case (opc)
                    OP_ADD, OP_XOR, OP_AND: begin
                        nxt_op1 = rd_val;
                        nxt_op2 = rs_val;
                    end
                    OP_ADDI: begin
                        nxt_op1 = rd_val;
                        nxt_op2 = DW'(imm8);
                    end
                    OP_SHL, OP_SHR: begin
                        nxt_op1 = rd_val;
                    end
                    OP_LOAD, OP_LOADC: begin
                        nxt_op1 = DW'(imm8);
                    end
                    OP_STORE: begin
                        nxt_op1   = DW'(imm8);
                        nxt_store = rd_val;
                    end
                    default: begin
                        nxt_op1 = '0;
                    end
                endcase
            end
        end
    end

    // ID/EX boundary register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid      <= 1'b0;
            id_mode       <= '0;
            id_operand1   <= '0;
            id_operand2   <= '0;
            id_store_data <= '0;
            id_rd         <= '0;
            id_wr_en      <= 1'b0;
        end else begin
            id_valid      <= nxt_valid;
            id_mode       <= nxt_mode;
            id_operand1   <= nxt_op1;
            id_operand2   <= nxt_op2;
            id_store_data <= nxt_store;
            id_rd         <= nxt_rd;
            id_wr_en      <= nxt_wr_en;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a behavioural model of the ID/EX register and the
// register file checked against the DUT every cycle, plus hand-computed
// expectations for the key scenarios.
module tb_decode_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic        if_stall;
    logic [7:0]  ex_alu_out = '0;
    logic        mem_fwd_en = 1'b0;
    logic [1:0]  mem_fwd_rd = '0;
    logic [7:0]  mem_fwd_data = '0;
    logic        wb_en = 1'b0;
    logic [1:0]  wb_rd = '0;
    logic [7:0]  wb_data = '0;
    logic        id_valid;
    logic [3:0]  id_mode;
    logic [7:0]  id_operand1;
    logic [7:0]  id_operand2;
    logic [7:0]  id_store_data;
    logic [1:0]  id_rd;
    logic        id_wr_en;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_stall      (if_stall),
        .ex_alu_out    (ex_alu_out),
        .mem_fwd_en    (mem_fwd_en),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .id_valid      (id_valid),
        .id_mode       (id_mode),
        .id_operand1   (id_operand1),
        .id_operand2   (id_operand2),
        .id_store_data (id_store_data),
        .id_rd         (id_rd),
        .id_wr_en      (id_wr_en)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       valid;
        logic [3:0] mode;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] sd;
        logic [1:0] rd;
        logic       wr;
    } id_t;

    id_t        m_id = '0;
    logic [7:0] m_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    // Value an instruction sees for register src: newest producer wins.
    function automatic logic [7:0] m_read(input logic [1:0] src);
        if (m_id.valid && m_id.wr && m_id.rd == src && m_id.mode != 4'h2) return ex_alu_out;
        if (mem_fwd_en && mem_fwd_rd == src) return mem_fwd_data;
        if (wb_en && wb_rd == src) return wb_data;
        return m_regs[src];
    endfunction

    function automatic logic m_reads_rd(input logic [3:0] op);
        return op inside {4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    endfunction

    function automatic logic m_reads_rs(input logic [3:0] op);
        return op inside {4'h1, 4'h5, 4'h6};
    endfunction

    function automatic logic m_stall();
        logic [3:0] op = if_instr[15:12];
        logic [1:0] rd = if_instr[11:10];
        logic [1:0] rs = if_instr[9:8];
        if (!(if_valid && m_id.valid && m_id.wr && m_id.mode == 4'h2)) return 1'b0;
        return (m_reads_rd(op) && rd == m_id.rd) || (m_reads_rs(op) && rs == m_id.rd);
    endfunction

    function automatic id_t m_next();
        id_t        n = '0;
        logic [3:0] op = if_instr[15:12];
        logic [1:0] rd = if_instr[11:10];
        logic [1:0] rs = if_instr[9:8];
        logic [7:0] imm = if_instr[7:0];
        if (!if_valid || m_stall()) return n;
        n.valid = 1'b1;
        if (op > 4'h9) return n;
        n.mode = op;
        case (op)
            4'h1, 4'h5, 4'h6: begin n.op1 = m_read(rd); n.op2 = m_read(rs); end
            4'h9:             begin n.op1 = m_read(rd); n.op2 = imm; end
            4'h7, 4'h8:       n.op1 = m_read(rd);
            4'h2, 4'h4:       n.op1 = imm;
            4'h3:             begin n.op1 = imm; n.sd = m_read(rd); end
            default:          n.op1 = 8'h00;
        endcase
        n.wr = op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        n.rd = n.wr ? rd : 2'd0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_id <= '0;
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
        end else begin
            m_id <= m_next();
            if (wb_en) m_regs[wb_rd] <= wb_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("id_valid", {7'b0, id_valid}, {7'b0, m_id.valid});
            check("id_mode", {4'b0, id_mode}, {4'b0, m_id.mode});
            check("id_operand1", id_operand1, m_id.op1);
            check("id_operand2", id_operand2, m_id.op2);
            check("id_store_data", id_store_data, m_id.sd);
            check("id_rd", {6'b0, id_rd}, {6'b0, m_id.rd});
            check("id_wr_en", {7'b0, id_wr_en}, {7'b0, m_id.wr});
            check("if_stall", {7'b0, if_stall}, {7'b0, m_stall()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic v, input logic [15:0] instr);
        if_valid     = v;
        if_instr     = instr;
        ex_alu_out   = 8'h00;
        mem_fwd_en   = 1'b0;
        mem_fwd_rd   = 2'd0;
        mem_fwd_data = 8'h00;
        wb_en        = 1'b0;
        wb_rd        = 2'd0;
        wb_data      = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  ex;
        logic        men;
        logic [1:0]  mrd;
        logic [7:0]  mdat;
    } vec_t;

    // Mixed directed vectors; stalled instructions appear twice (held by IF).
    vec_t vecs [12] = '{
        '{16'h5B00, 8'h66, 1'b0, 2'd0, 8'h00},  // XOR R2,R3
        '{16'h6200, 8'hD8, 1'b0, 2'd0, 8'h00},  // AND R0,R2 (R2 from EX)
        '{16'h8800, 8'h00, 1'b1, 2'd2, 8'hD8},  // SHR R2
        '{16'h2C40, 8'h6C, 1'b0, 2'd0, 8'h00},  // LOAD R3,0x40
        '{16'h4C11, 8'h40, 1'b0, 2'd0, 8'h00},  // LOADC R3 (no read, no stall)
        '{16'h2850, 8'h11, 1'b1, 2'd3, 8'hAB},  // LOAD R2,0x50
        '{16'h3860, 8'h50, 1'b0, 2'd0, 8'h00},  // STORE R2 -> stall
        '{16'h3860, 8'h00, 1'b1, 2'd2, 8'hC3},  // STORE R2 re-decode
        '{16'h2000, 8'h60, 1'b0, 2'd0, 8'h00},  // LOAD R0,0x00
        '{16'h1400, 8'h00, 1'b0, 2'd0, 8'h00},  // ADD R1,R0 -> stall on rs
        '{16'h1400, 8'h00, 1'b1, 2'd0, 8'h5E},  // ADD R1,R0 re-decode
        '{16'hA000, 8'h5F, 1'b0, 2'd0, 8'h00}   // illegal
    };

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        #1;
        check("reset id_valid", {7'b0, id_valid}, 8'h00);
        check("reset if_stall", {7'b0, if_stall}, 8'h00);
        check("reset id_operand1", id_operand1, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back forwarding
        issue(1'b1, 16'h4405); tick();              // LOADC R1,0x05
        check("loadc mode", {4'b0, id_mode}, 8'h04);
        check("loadc op1", id_operand1, 8'h05);
        check("loadc rd", {6'b0, id_rd}, 8'h01);
        issue(1'b1, 16'h4803); ex_alu_out = 8'h05; tick();  // LOADC R2,0x03
        issue(1'b1, 16'h1600); ex_alu_out = 8'h03;          // ADD R1,R2
        mem_fwd_en = 1'b1; mem_fwd_rd = 2'd1; mem_fwd_data = 8'h05;
        #1 check("fwd no stall", {7'b0, if_stall}, 8'h00);
        tick();
        check("fwd add mode", {4'b0, id_mode}, 8'h01);
        check("fwd add op1 mem", id_operand1, 8'h05);
        check("fwd add op2 ex", id_operand2, 8'h03);

        // Load-use: R1 = 0x01 via WB, then LOAD R0 followed by ADD R0,R1
        issue(1'b0, 16'h0000); ex_alu_out = 8'h08;
        wb_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h01; tick();
        issue(1'b1, 16'h2010); tick();              // LOAD R0,0x10
        check("load mode", {4'b0, id_mode}, 8'h02);
        check("load op1", id_operand1, 8'h10);
        issue(1'b1, 16'h1100); ex_alu_out = 8'h10;  // ADD R0,R1
        #1 check("load-use stall", {7'b0, if_stall}, 8'h01);
        tick();
        check("load-use bubble valid", {7'b0, id_valid}, 8'h00);
        check("load-use bubble mode", {4'b0, id_mode}, 8'h00);
        issue(1'b1, 16'h1100);
        mem_fwd_en = 1'b1; mem_fwd_rd = 2'd0; mem_fwd_data = 8'h7A;
        #1 check("load-use stall released", {7'b0, if_stall}, 8'h00);
        tick();
        check("load-use add valid", {7'b0, id_valid}, 8'h01);
        check("load-use add op1", id_operand1, 8'h7A);
        check("load-use add op2", id_operand2, 8'h01);

        // WB write-through into SHL R3
        issue(1'b1, 16'h7C00); ex_alu_out = 8'h7B;
        wb_en = 1'b1; wb_rd = 2'd3; wb_data = 8'h44; tick();
        check("shl op1 wb", id_operand1, 8'h44);
        check("shl op2", id_operand2, 8'h00);
        check("shl wr_en", {7'b0, id_wr_en}, 8'h01);

        // STORE R2,0x20 with R2 = 0x9C
        issue(1'b0, 16'h0000); wb_en = 1'b1; wb_rd = 2'd2; wb_data = 8'h9C; tick();
        issue(1'b1, 16'h3820); tick();
        check("store mode", {4'b0, id_mode}, 8'h03);
        check("store op1", id_operand1, 8'h20);
        check("store data", id_store_data, 8'h9C);
        check("store wr_en", {7'b0, id_wr_en}, 8'h00);

        // Illegal opcode, then idle cycle
        issue(1'b1, 16'hF000); tick();
        check("illegal valid", {7'b0, id_valid}, 8'h01);
        check("illegal mode", {4'b0, id_mode}, 8'h00);
        check("illegal wr_en", {7'b0, id_wr_en}, 8'h00);
        issue(1'b0, 16'h0000);
        #1 check("idle stall", {7'b0, if_stall}, 8'h00);
        tick();
        check("idle valid", {7'b0, id_valid}, 8'h00);

        // EX beats MEM and WB on the same register, both operands
        issue(1'b1, 16'h9402); tick();              // ADDI R1,0x02
        check("addi op1", id_operand1, 8'h01);
        check("addi op2", id_operand2, 8'h02);
        issue(1'b1, 16'h1500); ex_alu_out = 8'h33;  // ADD R1,R1
        mem_fwd_en = 1'b1; mem_fwd_rd = 2'd1; mem_fwd_data = 8'h44;
        wb_en = 1'b1; wb_rd = 2'd1; wb_data = 8'h55; tick();
        check("ex wins op1", id_operand1, 8'h33);
        check("ex wins op2", id_operand2, 8'h33);

        // Model-checked vector table
        for (int i = 0; i < 12; i++) begin
            issue(1'b1, vecs[i].instr);
            ex_alu_out   = vecs[i].ex;
            mem_fwd_en   = vecs[i].men;
            mem_fwd_rd   = vecs[i].mrd;
            mem_fwd_data = vecs[i].mdat;
            tick();
        end

        // Reset during a stall cancels the held instruction
        issue(1'b1, 16'h2400); tick();              // LOAD R1,0x00
        issue(1'b1, 16'h1500);                      // ADD R1,R1 -> stall
        #1 check("pre-reset stall", {7'b0, if_stall}, 8'h01);
        #1 rst = 1'b1;
        #1;
        check("mid reset valid", {7'b0, id_valid}, 8'h00);
        check("mid reset mode", {4'b0, id_mode}, 8'h00);
        check("mid reset stall", {7'b0, if_stall}, 8'h00);
        tick();
        rst = 1'b0;
        issue(1'b1, 16'h1100); tick();              // ADD R0,R1
        check("post reset mode", {4'b0, id_mode}, 8'h01);
        check("post reset op1", id_operand1, 8'h00);
        check("post reset op2", id_operand2, 8'h00);

        issue(1'b0, 16'h0000);
        repeat (2) tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
